// File: rtl/fix_serializer_pkg.sv
// Shared constants, group tables and body-length helper for the FIX body serializer.
package fix_serializer_pkg;

    localparam logic [7:0]  SOH_DEFAULT = 8'h01;
    localparam logic [7:0]  EQ_CHAR     = 8'h3D;
    localparam int unsigned NUM_GROUPS  = 11;
    localparam int unsigned TAG_W       = 40;

    typedef enum logic [3:0] {
        GRP_MSGTYPE   = 4'd0,
        GRP_SENDER    = 4'd1,
        GRP_TARGET    = 4'd2,
        GRP_TARGETSUB = 4'd3,
        GRP_CLORDID   = 4'd4,
        GRP_ORDERID   = 4'd5,
        GRP_ACCOUNT   = 4'd6,
        GRP_PRICE     = 4'd7,
        GRP_QTY       = 4'd8,
        GRP_ORDTYPE   = 4'd9,
        GRP_EXCODE    = 4'd10
    } groupT;

    // Tag digits are right-justified; the MS tag char sits at byte TAG_LEN-1.
    localparam logic [TAG_W-1:0] TAG_STR [NUM_GROUPS] = '{
        40'("35"), 40'("49"), 40'("56"), 40'("57"), 40'("11"), 40'("37"),
        40'("1"),  40'("44"), 40'("38"), 40'("40"), 40'("10000")
    };
    localparam logic [3:0] TAG_LEN [NUM_GROUPS] = '{
        4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd1, 4'd2, 4'd2, 4'd2, 4'd5
    };
    localparam logic [3:0] VAL_LEN [NUM_GROUPS] = '{
        4'd1, 4'd7, 4'd4, 4'd1, 4'd12, 4'd5, 4'd7, 4'd9, 4'd3, 4'd1, 4'd1
    };

    // Each group is tag + '=' + value + SOH; the exchange-code group is last.
    function automatic int unsigned bodyLen(input bit includeExcode);
        int unsigned n;
        n = 0;
        for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
            if (includeExcode || (g != NUM_GROUPS - 1))
                n = n + 32'(TAG_LEN[g]) + 32'(VAL_LEN[g]) + 2;
        end
        return n;
    endfunction

endpackage

// File: rtl/fix_tag_rom.sv
// Combinational lookup of tag byte ('=' after the digits) and field lengths per group.
module fix_tag_rom
    import fix_serializer_pkg::*;
(
    input  logic [3:0] grp,
    input  logic [3:0] idx,
    output logic [7:0] tagByte,
    output logic [3:0] tagLen,
    output logic [3:0] valLen
);

    logic [3:0] tagDiff;

    always_comb begin
        tagByte = 8'h00;
        tagLen  = 4'd0;
        valLen  = 4'd0;
        tagDiff = 4'd0;
        if (grp < 4'(NUM_GROUPS)) begin
            tagLen  = TAG_LEN[grp];
            valLen  = VAL_LEN[grp];
            tagDiff = tagLen - idx - 4'd1;
            if (idx == tagLen)
                tagByte = EQ_CHAR;
            else if (idx < tagLen)
                tagByte = 8'(TAG_STR[grp] >> {tagDiff, 3'b000});
        end
    end

endmodule

// File: rtl/fix_order_serializer.sv
// Serializes one decoded order into a FIX body byte stream with running mod-256 checksum.
module fix_order_serializer
    import fix_serializer_pkg::*;
#(
    parameter bit         INCLUDE_EXCODE = 1'b1,
    parameter logic [7:0] SOH            = SOH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  MsgType,
    input  logic [71:0] Price,
    input  logic [23:0] OrderQty,
    input  logic [7:0]  TwseOrdType,
    input  logic [7:0]  TwseExCode,
    input  logic [55:0] SenderCompID,
    input  logic [31:0] TargetCompID,
    input  logic [7:0]  TargetSubID,
    input  logic [95:0] ClOrdID,
    input  logic [39:0] OrderID,
    input  logic [55:0] Account,
    output logic [7:0]  out_tdata,
    output logic        out_tvalid,
    input  logic        out_tready,
    output logic        out_tlast,
    output logic [7:0]  cksum,
    output logic        cksum_valid,
    output logic [7:0]  body_len
);

    localparam int unsigned BODY_LEN = bodyLen(INCLUDE_EXCODE);
    localparam logic [3:0]  LAST_GRP = INCLUDE_EXCODE ? GRP_EXCODE : GRP_ORDTYPE;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TAG  = 2'd1;
    localparam logic [1:0] S_VAL  = 2'd2;
    localparam logic [1:0] S_DLM  = 2'd3;

    logic [1:0]  state, nxtState;
    logic [3:0]  grp, nxtGrp, idx, nxtIdx;
    logic [3:0]  curTagLen, curValLen;
    logic [7:0]  acc;
    logic        capture, step, nxtLast;
    logic [7:0]  romTagByte, valByte, nxtByte;
    logic [3:0]  romTagLen, romValLen, valDiff;
    logic [95:0] fieldSel;

    logic [7:0]  msgTypeQ, ordTypeQ, exCodeQ, targetSubQ;
    logic [71:0] priceQ;
    logic [23:0] orderQtyQ;
    logic [55:0] senderQ, accountQ;
    logic [31:0] targetQ;
    logic [95:0] clOrdIdQ;
    logic [39:0] orderIdQ;

    assign capture  = in_valid && in_ready;
    assign step     = out_tvalid && out_tready;
    assign body_len = 8'(BODY_LEN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            grp   <= 4'd0;
            idx   <= 4'd0;
        end else begin
            state <= nxtState;
            grp   <= nxtGrp;
            idx   <= nxtIdx;
        end
    end

    // Position of the byte to present next; only moves on capture or handshake.
    always_comb begin
        nxtState = state;
        nxtGrp   = grp;
        nxtIdx   = idx;
        case (state)
            S_IDLE: if (capture) begin
                nxtState = S_TAG;
                nxtGrp   = 4'd0;
                nxtIdx   = 4'd0;
            end
            S_TAG: if (step) begin
                if (idx == curTagLen) begin
                    nxtState = S_VAL;
                    nxtIdx   = 4'd0;
                end else
                    nxtIdx = idx + 4'd1;
            end
            S_VAL: if (step) begin
                if (idx == curValLen - 4'd1) begin
                    nxtState = S_DLM;
                    nxtIdx   = 4'd0;
                end else
                    nxtIdx = idx + 4'd1;
            end
            S_DLM: if (step) begin
                nxtIdx = 4'd0;
                if (grp == LAST_GRP) begin
                    nxtState = S_IDLE;
                    nxtGrp   = 4'd0;
                end else begin
                    nxtState = S_TAG;
                    nxtGrp   = grp + 4'd1;
                end
            end
            default: nxtState = S_IDLE;
        endcase
    end

    fix_tag_rom uRom (
        .grp     (nxtGrp),
        .idx     (nxtIdx),
        .tagByte (romTagByte),
        .tagLen  (romTagLen),
        .valLen  (romValLen)
    );

    // Value characters are taken MS char first from the latched field.
    always_comb begin
        case (nxtGrp)
            GRP_MSGTYPE:   fieldSel = 96'(msgTypeQ);
            GRP_SENDER:    fieldSel = 96'(senderQ);
            GRP_TARGET:    fieldSel = 96'(targetQ);
            GRP_TARGETSUB: fieldSel = 96'(targetSubQ);
            GRP_CLORDID:   fieldSel = clOrdIdQ;
            GRP_ORDERID:   fieldSel = 96'(orderIdQ);
            GRP_ACCOUNT:   fieldSel = 96'(accountQ);
            GRP_PRICE:     fieldSel = 96'(priceQ);
            GRP_QTY:       fieldSel = 96'(orderQtyQ);
            GRP_ORDTYPE:   fieldSel = 96'(ordTypeQ);
            GRP_EXCODE:    fieldSel = 96'(exCodeQ);
            default:       fieldSel = '0;
        endcase
        valDiff = romValLen - nxtIdx - 4'd1;
        valByte = (nxtIdx < romValLen) ? 8'(fieldSel >> {valDiff, 3'b000}) : 8'h00;
        case (nxtState)
            S_TAG:   nxtByte = romTagByte;
            S_VAL:   nxtByte = valByte;
            S_DLM:   nxtByte = SOH;
            default: nxtByte = 8'h00;
        endcase
        nxtLast = (nxtState == S_DLM) && (nxtGrp == LAST_GRP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready    <= 1'b1;
            out_tvalid  <= 1'b0;
            out_tlast   <= 1'b0;
            out_tdata   <= 8'h00;
            cksum       <= 8'h00;
            cksum_valid <= 1'b0;
            acc         <= 8'h00;
            curTagLen   <= 4'd0;
            curValLen   <= 4'd0;
            msgTypeQ    <= '0;
            priceQ      <= '0;
            orderQtyQ   <= '0;
            ordTypeQ    <= '0;
            exCodeQ     <= '0;
            senderQ     <= '0;
            targetQ     <= '0;
            targetSubQ  <= '0;
            clOrdIdQ    <= '0;
            orderIdQ    <= '0;
            accountQ    <= '0;
        end else begin
            cksum_valid <= 1'b0;
            if (capture || step) begin
                out_tdata  <= nxtByte;
                out_tlast  <= nxtLast;
                out_tvalid <= (nxtState != S_IDLE);
                curTagLen  <= romTagLen;
                curValLen  <= romValLen;
            end
            if (capture) begin
                in_ready   <= 1'b0;
                acc        <= 8'h00;
                msgTypeQ   <= MsgType;
                priceQ     <= Price;
                orderQtyQ  <= OrderQty;
                ordTypeQ   <= TwseOrdType;
                exCodeQ    <= TwseExCode;
                senderQ    <= SenderCompID;
                targetQ    <= TargetCompID;
                targetSubQ <= TargetSubID;
                clOrdIdQ   <= ClOrdID;
                orderIdQ   <= OrderID;
                accountQ   <= Account;
            end
            if (step) begin
                acc <= acc + out_tdata;
                if (out_tlast) begin
                    cksum       <= acc + out_tdata;
                    cksum_valid <= 1'b1;
                    in_ready    <= 1'b1;
                end
            end
        end
    end

endmodule
